// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_unit
// Purpose  : Program-counter register with branch/JAL/JALR redirect selection,
//            misaligned-target trap, optional branch statistics (BRANCH_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_en,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        trap,
    output logic [31:0] trap_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] br_total_cnt,
    output logic [31:0] br_taken_cnt
`endif
);

    localparam logic [1:0]  c_ST_BOOT   = 2'd0;
    localparam logic [1:0]  c_ST_RUN    = 2'd1;
    localparam logic [1:0]  c_ST_TRAP   = 2'd2;
    localparam logic [31:0] c_INSN_SIZE = 32'd4;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_trap_pc;
    logic        r_trap;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_rel_target;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_jalr_target;
    logic [31:0] w_next_pc;
    logic        w_redirect;
    logic        w_misaligned;
    logic        w_advance;

    assign w_pc_plus4    = r_pc + c_INSN_SIZE;
    assign w_rel_target  = r_pc + imm;
    assign w_jalr_sum    = rs1_val + imm;
    assign w_jalr_target = w_jalr_sum & ~32'd1;

    // Target selection: jalr beats jal beats a taken conditional branch.
    always_comb begin
        w_next_pc  = w_pc_plus4;
        w_redirect = 1'b0;
        if (jalr) begin
            w_next_pc  = w_jalr_target;
            w_redirect = 1'b1;
        end else if (jal) begin
            w_next_pc  = w_rel_target;
            w_redirect = 1'b1;
        end else if (branch_en && branch_taken) begin
            w_next_pc  = w_rel_target;
            w_redirect = 1'b1;
        end
    end

    // Only a redirect can produce a misaligned target; sequential flow stays aligned.
    assign w_misaligned = w_redirect && (w_next_pc[1:0] != 2'b00);
    assign w_advance    = (r_state == c_ST_RUN) && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_BOOT;
            r_pc      <= RESET_PC;
            r_trap    <= 1'b0;
            r_trap_pc <= 32'd0;
        end else begin
            case (r_state)
                c_ST_BOOT: begin
                    r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (w_advance) begin
                        if (w_misaligned) begin
                            r_state   <= c_ST_TRAP;
                            r_trap    <= 1'b1;
                            r_trap_pc <= r_pc;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                c_ST_TRAP: begin
                    r_state <= c_ST_TRAP;
                end
                default: begin
                    r_state <= c_ST_BOOT;
                    r_pc    <= RESET_PC;
                end
            endcase
        end
    end

    assign pc_out      = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_valid = (r_state == c_ST_RUN);
    assign trap        = r_trap;
    assign trap_pc     = r_trap_pc;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_br_total;
    logic [31:0] r_br_taken;
    logic        w_count_branch;

    assign w_count_branch = w_advance && branch_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_total <= 32'd0;
            r_br_taken <= 32'd0;
        end else if (w_count_branch) begin
            r_br_total <= r_br_total + 32'd1;
            if (branch_taken) begin
                r_br_taken <= r_br_taken + 32'd1;
            end
        end
    end

    assign br_total_cnt = r_br_total;
    assign br_taken_cnt = r_br_taken;
`endif

endmodule
`default_nettype wire
